// File: rtl/ram_block_copier.sv
// ram_block_copier
// Bus-responder engine that, once granted the single-port RAM by the controller, either copies
// a block of words between two regions or fills a region with a constant word. It is used to
// scroll and clear text/frame buffers before a redraw.
//
// Ports:
//   CLOCK_50        system clock, rising edge
//   resetIn         asynchronous active-low reset
//   enable          grant from controller, held high for the whole transaction
//   acknowledge     transaction complete, held until enable is seen low
//   mode            0 = copy, 1 = fill (sampled at start)
//   srcBase         first source address (sampled at start)
//   dstBase         first destination address (sampled at start)
//   wordCount       number of words, 0..2^ADDR_W (sampled at start)
//   fillValue       fill word (sampled at start)
//   dataRead        RAM read data, valid READ_LATENCY cycles after the address
//   address         RAM word address
//   dataWrite       RAM write data
//   writeEnableRam  RAM write strobe
module ram_block_copier #(
   parameter int unsigned ADDR_W       = 11,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic              CLOCK_50,
   input  logic              resetIn,
   input  logic              enable,
   output logic              acknowledge,
   input  logic              mode,
   input  logic [ADDR_W-1:0] srcBase,
   input  logic [ADDR_W-1:0] dstBase,
   input  logic [ADDR_W:0]   wordCount,
   input  logic [DATA_W-1:0] fillValue,
   input  logic [DATA_W-1:0] dataRead,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] dataWrite,
   output logic              writeEnableRam
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   // READ is held READ_LATENCY+1 cycles; the wait counter runs 0..READ_LATENCY.
   localparam logic [1:0]      WaitLast = 2'(READ_LATENCY);
   localparam logic [ADDR_W:0] IdxOne   = (ADDR_W + 1)'(1);

   state_e            state_q, state_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] fill_q, fill_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W:0]   index_q, index_d;
   logic [1:0]        wait_q, wait_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;

   logic [ADDR_W:0]   index_inc;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;

   // Address sums are truncated to ADDR_W bits so regions wrap from the top of RAM to 0.
   assign index_inc = index_q + IdxOne;
   assign src_addr  = src_q + index_q[ADDR_W-1:0];
   assign dst_addr  = dst_q + index_q[ADDR_W-1:0];

   always_comb begin
      state_d        = state_q;
      mode_d         = mode_q;
      src_d          = src_q;
      dst_d          = dst_q;
      count_d        = count_q;
      fill_d         = fill_q;
      data_d         = data_q;
      index_d        = index_q;
      wait_d         = wait_q;
      last_addr_d    = last_addr_q;
      acknowledge    = 1'b0;
      address        = '0;
      dataWrite      = '0;
      writeEnableRam = 1'b0;

      unique case (state_q)
         StIdle: begin
            last_addr_d = '0;
            if (enable) begin
               mode_d  = mode;
               src_d   = srcBase;
               dst_d   = dstBase;
               count_d = wordCount;
               fill_d  = fillValue;
               index_d = '0;
               wait_d  = '0;
               if (wordCount == '0) begin
                  state_d = StDone;
               end else if (mode) begin
                  state_d = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead: begin
            address     = src_addr;
            last_addr_d = src_addr;
            if (!enable) begin
               state_d = StIdle;
            end else if (wait_q == WaitLast) begin
               data_d  = dataRead;
               wait_d  = '0;
               state_d = StWrite;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         StWrite: begin
            address        = dst_addr;
            last_addr_d    = dst_addr;
            dataWrite      = mode_q ? fill_q : data_q;
            // Gated with the grant so an abort cycle never writes.
            writeEnableRam = enable;
            if (!enable) begin
               state_d = StIdle;
            end else begin
               index_d = index_inc;
               if (index_inc == count_q) begin
                  state_d = StDone;
               end else if (!mode_q) begin
                  state_d = StRead;
               end
            end
         end
         StDone: begin
            acknowledge = 1'b1;
            address     = last_addr_q;
            if (!enable) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetIn) begin
      if (!resetIn) begin
         state_q     <= StIdle;
         mode_q      <= 1'b0;
         src_q       <= '0;
         dst_q       <= '0;
         count_q     <= '0;
         fill_q      <= '0;
         data_q      <= '0;
         index_q     <= '0;
         wait_q      <= '0;
         last_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         count_q     <= count_d;
         fill_q      <= fill_d;
         data_q      <= data_d;
         index_q     <= index_d;
         wait_q      <= wait_d;
         last_addr_q <= last_addr_d;
      end
   end

endmodule

// File: tb/tb_ram_block_copier.sv
// Directed bench for ram_block_copier. Three instances share the controller inputs and differ
// only in READ_LATENCY (1, 2, 3); each has its own RAM model of matching latency and its own
// enable. Instance 0 carries the functional tests, instances 1 and 2 the latency sweep.
module tb_ram_block_copier;

   logic        clk;
   logic        resetIn;
   logic        mode;
   logic [10:0] srcBase;
   logic [10:0] dstBase;
   logic [11:0] wordCount;
   logic [31:0] fillValue;

   logic        en    [3];
   logic        ack   [3];
   logic [10:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic        we    [3];

   logic [31:0] mem    [3][2048];
   logic [31:0] pipe   [3][3];
   int          we_cnt [3];

   logic        pl_en;
   int          pl_k;
   logic [10:0] pl_addr;
   logic [31:0] pl_data;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [31:0] Sentinel = 32'hFFFF_FFFF;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ram_block_copier #(
         .ADDR_W      (11),
         .DATA_W      (32),
         .READ_LATENCY(g + 1)
      ) u_dut (
         .CLOCK_50      (clk),
         .resetIn       (resetIn),
         .enable        (en[g]),
         .acknowledge   (ack[g]),
         .mode          (mode),
         .srcBase       (srcBase),
         .dstBase       (dstBase),
         .wordCount     (wordCount),
         .fillValue     (fillValue),
         .dataRead      (rdata[g]),
         .address       (addr[g]),
         .dataWrite     (wdata[g]),
         .writeEnableRam(we[g])
      );
      assign rdata[g] = pipe[g][g];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models: synchronous write, read data delayed by a per-instance pipeline.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (pl_en && pl_k == k) begin
            mem[k][pl_addr] <= pl_data;
         end else if (we[k]) begin
            mem[k][addr[k]] <= wdata[k];
         end
         if (we[k]) we_cnt[k] <= we_cnt[k] + 1;
         pipe[k][0] <= mem[k][addr[k]];
         pipe[k][1] <= pipe[k][0];
         pipe[k][2] <= pipe[k][1];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic poke(input int k, input int a, input logic [31:0] d);
      pl_en   = 1'b1;
      pl_k    = k;
      pl_addr = a[10:0];
      pl_data = d;
      tick();
      pl_en   = 1'b0;
   endtask

   // Raises enable, then counts edges until acknowledge; the start edge counts as 1.
   task automatic run_until_ack(input int k, output int cyc);
      cyc   = 0;
      en[k] = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick();
         cyc++;
         if (ack[k]) break;
      end
      if (!ack[k]) cyc = -1;
   endtask

   initial begin
      int cyc;
      int base;
      logic ack_seen;

      resetIn   = 1'b0;
      mode      = 1'b0;
      srcBase   = '0;
      dstBase   = '0;
      wordCount = '0;
      fillValue = '0;
      pl_en     = 1'b0;
      pl_k      = 0;
      pl_addr   = '0;
      pl_data   = '0;
      for (int k = 0; k < 3; k++) begin
         en[k]     = 1'b0;
         we_cnt[k] = 0;
      end
      #1;
      chk("reset_ack", 64'(ack[0]), 64'd0);
      chk("reset_addr", 64'(addr[0]), 64'd0);
      chk("reset_wdata", 64'(wdata[0]), 64'd0);
      chk("reset_we", 64'(we[0]), 64'd0);
      tick();
      resetIn = 1'b1;
      tick();

      // ---- Copy 4 words 10..13 -> 100..103, latency 1
      poke(0, 10, 32'hA000_000A);
      poke(0, 11, 32'hB000_000B);
      poke(0, 12, 32'hC000_000C);
      poke(0, 13, 32'hD000_000D);
      for (int i = 100; i < 104; i++) poke(0, i, Sentinel);
      mode      = 1'b0;
      srcBase   = 11'd10;
      dstBase   = 11'd100;
      wordCount = 12'd4;
      base      = we_cnt[0];
      en[0]     = 1'b1;
      tick();
      // Changes after the start edge must be ignored.
      srcBase   = 11'd500;
      dstBase   = 11'd900;
      wordCount = 12'd1;
      mode      = 1'b1;
      cyc = 1;
      for (int i = 0; i < 100 && !ack[0]; i++) begin
         tick();
         cyc++;
      end
      chk("copy_ack_cycle", 64'(cyc), 64'd13);
      chk("copy_write_count", 64'(we_cnt[0] - base), 64'd4);
      chk("copy_w0", 64'(mem[0][100]), 64'hA000_000A);
      chk("copy_w1", 64'(mem[0][101]), 64'hB000_000B);
      chk("copy_w2", 64'(mem[0][102]), 64'hC000_000C);
      chk("copy_w3", 64'(mem[0][103]), 64'hD000_000D);
      chk("copy_done_addr", 64'(addr[0]), 64'd103);
      en[0] = 1'b0;
      #1;
      chk("copy_ack_hold", 64'(ack[0]), 64'd1);
      tick();
      chk("copy_ack_fall", 64'(ack[0]), 64'd0);

      // ---- Fill 4 words at 2046 with wrap
      poke(0, 2045, Sentinel);
      poke(0, 2046, Sentinel);
      poke(0, 2047, Sentinel);
      poke(0, 0, Sentinel);
      poke(0, 1, Sentinel);
      poke(0, 2, Sentinel);
      mode      = 1'b1;
      dstBase   = 11'd2046;
      wordCount = 12'd4;
      fillValue = 32'h0000_0007;
      base      = we_cnt[0];
      en[0]     = 1'b1;
      tick();
      chk("fill_c1_we", 64'(we[0]), 64'd1);
      chk("fill_c1_addr", 64'(addr[0]), 64'd2046);
      chk("fill_c1_data", 64'(wdata[0]), 64'd7);
      tick();
      chk("fill_c2_addr", 64'(addr[0]), 64'd2047);
      chk("fill_c2_we", 64'(we[0]), 64'd1);
      tick();
      chk("fill_c3_addr", 64'(addr[0]), 64'd0);
      tick();
      chk("fill_c4_addr", 64'(addr[0]), 64'd1);
      chk("fill_c4_ack", 64'(ack[0]), 64'd0);
      tick();
      chk("fill_c5_ack", 64'(ack[0]), 64'd1);
      chk("fill_c5_we", 64'(we[0]), 64'd0);
      chk("fill_c5_addr_hold", 64'(addr[0]), 64'd1);
      chk("fill_count", 64'(we_cnt[0] - base), 64'd4);
      chk("fill_m2046", 64'(mem[0][2046]), 64'd7);
      chk("fill_m2047", 64'(mem[0][2047]), 64'd7);
      chk("fill_m0", 64'(mem[0][0]), 64'd7);
      chk("fill_m1", 64'(mem[0][1]), 64'd7);
      chk("fill_m2045_untouched", 64'(mem[0][2045]), 64'(Sentinel));
      chk("fill_m2_untouched", 64'(mem[0][2]), 64'(Sentinel));
      en[0] = 1'b0;
      tick();
      chk("fill_ack_fall", 64'(ack[0]), 64'd0);

      // ---- Zero count: immediate acknowledge, no restart while enable stays high
      mode      = 1'b0;
      wordCount = 12'd0;
      base      = we_cnt[0];
      run_until_ack(0, cyc);
      chk("zero_ack_cycle", 64'(cyc), 64'd1);
      repeat (10) tick();
      chk("zero_ack_held", 64'(ack[0]), 64'd1);
      chk("zero_no_writes", 64'(we_cnt[0] - base), 64'd0);
      en[0] = 1'b0;
      tick();
      chk("zero_ack_fall", 64'(ack[0]), 64'd0);

      // ---- Abort an 8-word copy after the 3rd write, then rerun it
      for (int i = 0; i < 8; i++) begin
         poke(0, 200 + i, 32'h0000_0200 + 32'(i));
         poke(0, 300 + i, Sentinel);
      end
      mode      = 1'b0;
      srcBase   = 11'd200;
      dstBase   = 11'd300;
      wordCount = 12'd8;
      base      = we_cnt[0];
      ack_seen  = 1'b0;
      en[0]     = 1'b1;
      for (int i = 0; i < 100 && (we_cnt[0] - base) < 3; i++) begin
         tick();
         if (ack[0]) ack_seen = 1'b1;
      end
      en[0] = 1'b0;
      tick();
      if (ack[0]) ack_seen = 1'b1;
      repeat (3) tick();
      chk("abort_writes", 64'(we_cnt[0] - base), 64'd3);
      chk("abort_no_ack", 64'(ack_seen), 64'd0);
      chk("abort_idle_addr", 64'(addr[0]), 64'd0);
      chk("abort_m302", 64'(mem[0][302]), 64'h0000_0202);
      chk("abort_m303_untouched", 64'(mem[0][303]), 64'(Sentinel));
      base = we_cnt[0];
      run_until_ack(0, cyc);
      chk("rerun_ack_cycle", 64'(cyc), 64'd25);
      chk("rerun_writes", 64'(we_cnt[0] - base), 64'd8);
      chk("rerun_m303", 64'(mem[0][303]), 64'h0000_0203);
      chk("rerun_m307", 64'(mem[0][307]), 64'h0000_0207);
      en[0] = 1'b0;
      tick();

      // ---- Write strobe is gated by enable within the abort cycle
      poke(0, 600, Sentinel);
      mode      = 1'b1;
      dstBase   = 11'd600;
      wordCount = 12'd4;
      fillValue = 32'h0000_0055;
      en[0]     = 1'b1;
      tick();
      chk("gate_we_high", 64'(we[0]), 64'd1);
      en[0] = 1'b0;
      #1;
      chk("gate_we_low", 64'(we[0]), 64'd0);
      tick();
      chk("gate_m600_untouched", 64'(mem[0][600]), 64'(Sentinel));
      chk("gate_idle_addr", 64'(addr[0]), 64'd0);

      // ---- Reset in the middle of a fill
      poke(0, 700, Sentinel);
      poke(0, 701, Sentinel);
      mode      = 1'b1;
      dstBase   = 11'd700;
      wordCount = 12'd5;
      fillValue = 32'h0000_0099;
      en[0]     = 1'b1;
      tick();
      tick();
      chk("rst_pre_addr", 64'(addr[0]), 64'd701);
      resetIn = 1'b0;
      #1;
      chk("rst_we", 64'(we[0]), 64'd0);
      chk("rst_ack", 64'(ack[0]), 64'd0);
      chk("rst_addr", 64'(addr[0]), 64'd0);
      en[0] = 1'b0;
      tick();
      resetIn = 1'b1;
      tick();
      chk("rst_idle_addr", 64'(addr[0]), 64'd0);
      chk("rst_idle_we", 64'(we[0]), 64'd0);
      chk("rst_m700", 64'(mem[0][700]), 64'h0000_0099);
      chk("rst_m701_untouched", 64'(mem[0][701]), 64'(Sentinel));

      // ---- Latency sweep: 4-word copy 20..23 -> 40..43 at latency 2 and 3
      for (int k = 1; k < 3; k++) begin
         for (int i = 0; i < 4; i++) begin
            poke(k, 20 + i, 32'h1234_0000 + 32'(k * 16 + i));
            poke(k, 40 + i, Sentinel);
         end
      end
      mode      = 1'b0;
      srcBase   = 11'd20;
      dstBase   = 11'd40;
      wordCount = 12'd4;
      run_until_ack(1, cyc);
      chk("lat2_ack_cycle", 64'(cyc), 64'd17);
      chk("lat2_m40", 64'(mem[1][40]), 64'h1234_0010);
      chk("lat2_m43", 64'(mem[1][43]), 64'h1234_0013);
      en[1] = 1'b0;
      tick();
      run_until_ack(2, cyc);
      chk("lat3_ack_cycle", 64'(cyc), 64'd21);
      chk("lat3_m40", 64'(mem[2][40]), 64'h1234_0020);
      chk("lat3_m43", 64'(mem[2][43]), 64'h1234_0023);
      chk("lat3_writes", 64'(we_cnt[2]), 64'd4);
      en[2] = 1'b0;
      tick();
      chk("lat3_ack_fall", 64'(ack[2]), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
